// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction channel, write-back forwarding port and ALU-facing outputs.
// The stage side uses the slave modport; the producer/consumer side uses master.
interface alu_issue_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_aluop;
  logic [RW-1:0] in_rs_idx;
  logic [RW-1:0] in_rt_idx;
  logic [RW-1:0] in_rd_idx;
  logic [DW-1:0] in_rs_val;
  logic [DW-1:0] in_rt_val;
  logic [15:0]   in_imm;
  logic          in_use_imm;
  logic          in_imm_sext;
  logic          fwd_we;
  logic [RW-1:0] fwd_idx;
  logic [DW-1:0] fwd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic [3:0]    ALUop;
  logic [RW-1:0] out_rd_idx;

  modport slave (
    input  in_valid, in_aluop, in_rs_idx, in_rt_idx, in_rd_idx, in_rs_val, in_rt_val,
    input  in_imm, in_use_imm, in_imm_sext, fwd_we, fwd_idx, fwd_data, out_ready,
    output in_ready, out_valid, A, B, ALUop, out_rd_idx
  );

  modport master (
    output in_valid, in_aluop, in_rs_idx, in_rt_idx, in_rd_idx, in_rs_val, in_rt_val,
    output in_imm, in_use_imm, in_imm_sext, fwd_we, fwd_idx, fwd_data, out_ready,
    input  in_ready, out_valid, A, B, ALUop, out_rd_idx
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: main + skid buffer with registered in_ready, immediate select and flush.
// Write-back forwarding into captured/buffered operands is enabled by defining ISSUE_FWD_EN.
module alu_issue_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  alu_issue_if.slave bus
);

  typedef struct packed {
    logic [3:0]    aluop;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic          b_is_imm;
  } entry_t;

  entry_t        main_q, main_d, skid_q, skid_d;
  entry_t        cap, cap_fw, main_fw, skid_fw;
  logic          main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic          accept, pop;
  logic [DW-1:0] ext_imm;

`ifdef ISSUE_FWD_EN
  // Register 0 is hard-wired, so a write-back to it never forwards.
  function automatic entry_t apply_fwd(input entry_t e, input logic we,
                                       input logic [RW-1:0] idx, input logic [DW-1:0] data);
    entry_t r;
    r = e;
    if (we && (idx != '0)) begin
      if (e.rs_idx == idx) r.a = data;
      if (!e.b_is_imm && (e.rt_idx == idx)) r.b = data;
    end
    return r;
  endfunction
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_we, bus.fwd_idx, bus.fwd_data,
                        main_q.rs_idx, main_q.rt_idx, main_q.b_is_imm};
`endif

  always_comb begin
    ext_imm = bus.in_imm_sext ? {{(DW-16){bus.in_imm[15]}}, bus.in_imm}
                              : {{(DW-16){1'b0}}, bus.in_imm};
    cap.aluop    = bus.in_aluop;
    cap.a        = bus.in_rs_val;
    cap.b        = bus.in_use_imm ? ext_imm : bus.in_rt_val;
    cap.rs_idx   = bus.in_rs_idx;
    cap.rt_idx   = bus.in_rt_idx;
    cap.rd_idx   = bus.in_rd_idx;
    cap.b_is_imm = bus.in_use_imm;
`ifdef ISSUE_FWD_EN
    cap_fw  = apply_fwd(cap, bus.fwd_we, bus.fwd_idx, bus.fwd_data);
    main_fw = main_valid_q ? apply_fwd(main_q, bus.fwd_we, bus.fwd_idx, bus.fwd_data) : main_q;
    skid_fw = skid_valid_q ? apply_fwd(skid_q, bus.fwd_we, bus.fwd_idx, bus.fwd_data) : skid_q;
`else
    cap_fw  = cap;
    main_fw = main_q;
    skid_fw = skid_q;
`endif
  end

  assign accept = bus.in_valid && !skid_valid_q && !flush;
  assign pop    = main_valid_q && bus.out_ready;

  always_comb begin
    main_d       = main_fw;
    skid_d       = skid_fw;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Fields hold their values; only the valids drop.
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || pop) begin
      if (skid_valid_q) begin
        main_d       = skid_fw;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = cap_fw;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = cap_fw;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.A          = main_q.a;
  assign bus.B          = main_q.b;
  assign bus.ALUop      = main_q.aluop;
  assign bus.out_rd_idx = main_q.rd_idx;

endmodule
